// File: rtl/stopwatch_pkg.sv
// Shared definitions for the mm:ss stopwatch: state encoding, digit width
// and the fixed digit maxima of the seconds and minute-units positions.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    STOP = 2'b00,
    RUN  = 2'b01,
    LAP  = 2'b10
  } state_t;

  localparam int DIGIT_W = 4;

  localparam logic [DIGIT_W-1:0] SEC_LO_MAX = 4'd9;
  localparam logic [DIGIT_W-1:0] SEC_HI_MAX = 4'd5;
  localparam logic [DIGIT_W-1:0] MIN_LO_MAX = 4'd9;

  // The count advances in both RUN and LAP; only STOP freezes it.
  function automatic logic is_active(input state_t s);
    return (s == RUN) || (s == LAP);
  endfunction

endpackage

// File: rtl/stopwatch_mmss_bcd_digit.sv
// One BCD digit of the stopwatch. It counts 0..max when enabled and raises
// carry in the cycle where an enabled increment wraps it back to 0.
module bcd_digit
  import stopwatch_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               clr,
  input  logic [DIGIT_W-1:0] max,
  output logic [DIGIT_W-1:0] q,
  output logic               carry
);

  // Digit register: clear has priority, then wrap-or-increment on enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= (q == max) ? '0 : q + 4'd1;
    end
  end

  assign carry = en & (q == max);

endmodule

// File: rtl/stopwatch_mmss.sv
// mm:ss stopwatch with start/stop and lap buttons. Four chained BCD digits
// hold the live count; a lap register freezes the display while in LAP.
module stopwatch_mmss
  import stopwatch_pkg::*;
#(
  parameter int MAX_MIN_HI = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ce,
  input  logic        start_stop,
  input  logic        lap,
  input  logic        clr,
  output logic [15:0] disp,
  output logic        running,
  output logic        CO
);

  localparam logic [DIGIT_W-1:0] MIN_HI_MAX = DIGIT_W'(MAX_MIN_HI);

  state_t state;
  state_t next_state;

  logic ss_q;
  logic lap_q;
  logic ss_edge;
  logic lap_edge;
  logic latch_lap;
  logic count_en;
  logic clear;

  logic [DIGIT_W-1:0] sec_lo;
  logic [DIGIT_W-1:0] sec_hi;
  logic [DIGIT_W-1:0] min_lo;
  logic [DIGIT_W-1:0] min_hi;
  logic               sec_lo_carry;
  logic               sec_hi_carry;
  logic               min_lo_carry;
  logic               min_hi_carry;

  logic [15:0] live;
  logic [15:0] lap_reg;

  assign ss_edge  = start_stop & ~ss_q;
  assign lap_edge = lap & ~lap_q;

  // Counting depends on the state before the edge, so a start edge that
  // coincides with ce does not count and a stop edge still does.
  assign count_en = ce & is_active(state);
  assign clear    = clr & (state == STOP);
  assign live     = {min_hi, min_lo, sec_hi, sec_lo};

  // One-cycle delayed samples of the button levels for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_q  <= 1'b0;
      lap_q <= 1'b0;
    end else begin
      ss_q  <= start_stop;
      lap_q <= lap;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= STOP;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode; start_stop wins over a simultaneous lap edge.
  always_comb begin
    next_state = state;
    latch_lap  = 1'b0;
    case (state)
      STOP: begin
        if (ss_edge) next_state = RUN;
      end
      RUN: begin
        if (ss_edge) begin
          next_state = STOP;
        end else if (lap_edge) begin
          next_state = LAP;
          latch_lap  = 1'b1;
        end
      end
      LAP: begin
        if (ss_edge) begin
          next_state = STOP;
        end else if (lap_edge) begin
          next_state = RUN;
        end
      end
      default: next_state = STOP;
    endcase
  end

  // Registered running flag, kept in step with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running <= 1'b0;
    end else begin
      running <= is_active(next_state);
    end
  end

  // Lap register captures the live count on entry to LAP, cleared with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lap_reg <= '0;
    end else if (clear) begin
      lap_reg <= '0;
    end else if (latch_lap) begin
      lap_reg <= live;
    end
  end

  // Display source: frozen lap value only while in LAP.
  always_comb begin
    disp = (state == LAP) ? lap_reg : live;
  end

  bcd_digit u_sec_lo (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (count_en),
    .clr   (clear),
    .max   (SEC_LO_MAX),
    .q     (sec_lo),
    .carry (sec_lo_carry)
  );

  bcd_digit u_sec_hi (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (sec_lo_carry),
    .clr   (clear),
    .max   (SEC_HI_MAX),
    .q     (sec_hi),
    .carry (sec_hi_carry)
  );

  bcd_digit u_min_lo (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (sec_hi_carry),
    .clr   (clear),
    .max   (MIN_LO_MAX),
    .q     (min_lo),
    .carry (min_lo_carry)
  );

  bcd_digit u_min_hi (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (min_lo_carry),
    .clr   (clear),
    .max   (MIN_HI_MAX),
    .q     (min_hi),
    .carry (min_hi_carry)
  );

  // The top digit's carry is exactly ce while active at the final count.
  assign CO = min_hi_carry;

endmodule

// File: tb/tb_stopwatch_mmss.sv
// Self-checking bench for stopwatch_mmss. The reference keeps the elapsed
// time as a plain number of seconds and derives the BCD display from it.
module tb_stopwatch_mmss;

  localparam int MAX_MIN_HI = 5;
  localparam int WRAP       = (MAX_MIN_HI + 1) * 600;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ce = 1'b0;
  logic        start_stop = 1'b0;
  logic        lap = 1'b0;
  logic        clr = 1'b0;
  logic [15:0] disp;
  logic        running;
  logic        CO;

  int checks = 0;
  int errors = 0;

  // Reference: seconds elapsed, lap seconds, mode 0=stopped 1=run 2=lap.
  int m_sec;
  int m_lap;
  int m_mode;
  bit m_pss;
  bit m_plap;
  logic last_co;

  always #5 clk = ~clk;

  stopwatch_mmss #(.MAX_MIN_HI(MAX_MIN_HI)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ce         (ce),
    .start_stop (start_stop),
    .lap        (lap),
    .clr        (clr),
    .disp       (disp),
    .running    (running),
    .CO         (CO)
  );

  function automatic logic [15:0] enc(input int s);
    int m;
    int sc;
    m  = s / 60;
    sc = s % 60;
    return {4'(m / 10), 4'(m % 10), 4'(sc / 10), 4'(sc % 10)};
  endfunction

  task automatic checkVal(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    m_sec  = 0;
    m_lap  = 0;
    m_mode = 0;
    m_pss  = 0;
    m_plap = 0;
  endtask

  task automatic modelStep(input bit c, input bit s, input bit l, input bit k);
    bit ss_e;
    bit lap_e;
    int pre;
    ss_e  = s & ~m_pss;
    lap_e = l & ~m_plap;
    pre   = m_sec;
    if (m_mode != 0 && c) m_sec = (m_sec + 1) % WRAP;
    if (m_mode == 0 && k) begin
      m_sec = 0;
      m_lap = 0;
    end
    if (ss_e) begin
      m_mode = (m_mode == 0) ? 1 : 0;
    end else if (lap_e) begin
      if (m_mode == 1) begin
        m_lap  = pre;
        m_mode = 2;
      end else if (m_mode == 2) begin
        m_mode = 1;
      end
    end
    m_pss  = s;
    m_plap = l;
  endtask

  // Compare every DUT output against the reference for the current cycle.
  task automatic checkOutput();
    logic exp_co;
    exp_co = ce && (m_mode != 0) && (m_sec == WRAP - 1);
    checkVal("disp", disp, enc(m_mode == 2 ? m_lap : m_sec));
    checkVal("running", {15'd0, running}, {15'd0, m_mode != 0});
    checkVal("CO", {15'd0, CO}, {15'd0, exp_co});
    last_co = CO;
  endtask

  // Drive one cycle of inputs, check before the edge, advance the model.
  task automatic applyStimulus(input bit c, input bit s, input bit l, input bit k);
    ce         = c;
    start_stop = s;
    lap        = l;
    clr        = k;
    #3;
    checkOutput();
    @(posedge clk);
    modelStep(c, s, l, k);
    #1;
  endtask

  task automatic doReset();
    rst_n      = 1'b0;
    ce         = 1'b1;
    start_stop = 1'b0;
    lap        = 1'b0;
    clr        = 1'b0;
    #2;
    checkVal("reset_disp", disp, 16'h0000);
    checkVal("reset_running", {15'd0, running}, 16'h0000);
    checkVal("reset_CO", {15'd0, CO}, 16'h0000);
    ce = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    modelReset();
  endtask

  task automatic startRun();
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0);
  endtask

  task automatic countTicks(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1, 0, 0, 0);
  endtask

  initial begin
    bit ss_lvl;
    bit lap_lvl;
    modelReset();
    last_co = 1'b0;

    // Start then 65 ticks reads 01:05.
    doReset();
    startRun();
    countTicks(65);
    checkVal("lit_0105", disp, 16'h0105);
    checkVal("lit_run", {15'd0, running}, 16'h0001);

    // Wrap from 59:59 with the carry strobe on the wrapping tick only.
    doReset();
    startRun();
    countTicks(3598);
    checkVal("lit_5958", disp, 16'h5958);
    applyStimulus(1, 0, 0, 0);
    checkVal("lit_co_first", {15'd0, last_co}, 16'h0000);
    applyStimulus(1, 0, 0, 0);
    checkVal("lit_co_second", {15'd0, last_co}, 16'h0001);
    checkVal("lit_wrap", disp, 16'h0000);

    // Lap freezes the display while the live count keeps going.
    doReset();
    startRun();
    countTicks(10);
    applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0);
    countTicks(5);
    checkVal("lit_lap_hold", disp, 16'h0010);
    applyStimulus(0, 0, 1, 0);
    checkVal("lit_lap_release", disp, 16'h0015);
    applyStimulus(0, 0, 0, 0);

    // Clear in STOP wins over ce; clear in RUN is ignored.
    doReset();
    startRun();
    countTicks(7);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0);
    checkVal("lit_stop_0007", disp, 16'h0007);
    applyStimulus(1, 0, 0, 1);
    checkVal("lit_clr", disp, 16'h0000);
    startRun();
    countTicks(3);
    applyStimulus(0, 0, 0, 1);
    checkVal("lit_clr_run", disp, 16'h0003);

    // Stop edge with ce still counts that tick, then nothing more.
    doReset();
    startRun();
    countTicks(3);
    applyStimulus(1, 1, 0, 0);
    checkVal("lit_stop_tick", disp, 16'h0004);
    checkVal("lit_stopped", {15'd0, running}, 16'h0000);
    applyStimulus(1, 0, 0, 0);
    countTicks(4);
    checkVal("lit_frozen", disp, 16'h0004);

    // Asynchronous reset mid-run at 12:34 acts before the next edge.
    doReset();
    startRun();
    countTicks(754);
    checkVal("lit_1234", disp, 16'h1234);
    #2;
    rst_n = 1'b0;
    #1;
    checkVal("async_disp", disp, 16'h0000);
    checkVal("async_running", {15'd0, running}, 16'h0000);
    doReset();

    // Randomized button/clear/ce traffic with occasional resets.
    ss_lvl  = 0;
    lap_lvl = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) ss_lvl = ~ss_lvl;
      if ($urandom_range(0, 5) == 0) lap_lvl = ~lap_lvl;
      if ($urandom_range(0, 999) == 0) begin
        doReset();
        ss_lvl  = 0;
        lap_lvl = 0;
      end else begin
        applyStimulus(1'($urandom_range(0, 1)), ss_lvl, lap_lvl,
                      $urandom_range(0, 9) == 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stopwatch_mmss.md
STOPWATCH_MMSS -- requirements
Module: stopwatch_mmss

Interface
REQ-001 SHALL have parameter MAX_MIN_HI, default 5, meaning the upper minute-tens digit before wrap (range 0..9).
REQ-002 SHALL have port clk, input, 1, the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, the reset: asynchronous, active-low.
REQ-004 SHALL have port ce, input, 1, the 1 Hz single-cycle count strobe from the upstream N-ms/1 s enable generator.
REQ-005 SHALL have port start_stop, input, 1, the level from the debounced button; the block acts on its rising edge.
REQ-006 SHALL have port lap, input, 1, the level from the debounced button; the block acts on its rising edge.
REQ-007 SHALL have port clr, input, 1, the level request to clear the count.
REQ-008 SHALL have port disp, output, 16, BCD {min_hi,min_lo,sec_hi,sec_lo} for the display stage.
REQ-009 SHALL have port running, output, 1, high in RUN or LAP.
REQ-010 SHALL have port CO, output, 1, the carry strobe on wrap from MAX_MIN_HI9:59 to 00:00.

Function
REQ-011 SHALL hold a live count of four BCD digits: sec_lo 0-9, sec_hi 0-5, min_lo 0-9, min_hi 0-MAX_MIN_HI.
REQ-012 SHALL detect the rising edges of start_stop and lap with one registered sample each; edge = input & ~previous sample.
REQ-013 SHALL implement the states STOP, RUN and LAP.
REQ-014 STOP: start_stop edge -> RUN; lap edge ignored.
REQ-015 RUN: start_stop edge -> STOP; lap edge -> LAP, latching the live count into the lap register.
REQ-016 LAP: lap edge -> RUN; start_stop edge -> STOP.
REQ-017 SHALL treat simultaneous start_stop and lap edges as a start_stop edge only.
REQ-018 SHALL increment the live count on a clk edge where ce=1 and the state before that edge is RUN or LAP; the count updates the cycle after ce is sampled.
REQ-019 Digit carry: each digit wraps to 0 and carries into the next digit when at its maximum.
REQ-020 At MAX_MIN_HI9:59 the count SHALL wrap to 00:00.
REQ-021 CO SHALL be combinational: ce & (RUN|LAP) & (count == MAX_MIN_HI9:59); CO is high for exactly the ce cycle that causes the wrap.
REQ-022 disp SHALL show the lap register in LAP and the live count otherwise, including STOP entered from LAP.
REQ-023 clr SHALL act only in STOP: the live count and the lap register go to 0 on the next edge.
REQ-024 clr SHALL be ignored in RUN and LAP.
REQ-025 If clr and ce coincide in STOP, clr SHALL win; ce has no effect in STOP anyway.
REQ-026 If a start_stop edge coincides with ce, the count SHALL follow the pre-edge state: RUN->STOP still counts that tick, and STOP->RUN does not.
REQ-027 running SHALL be registered, decoded from the state.

Reset
REQ-028 rst_n low SHALL immediately force: state STOP, live count 0, lap register 0, edge-detect samples 0.
REQ-029 During reset the outputs SHALL be disp=16'h0000, running=0 and CO=0.
REQ-030 A reset mid-count SHALL discard the count; after release the block SHALL wait in STOP.
REQ-031 Release SHALL be synchronous to clk externally; the block does not resynchronise rst_n.

Structure
REQ-032 The state encoding (STOP=2'b00, RUN=2'b01, LAP=2'b10), the BCD digit width (4) and the digit maxima (9, 5) SHALL live in the shared package stopwatch_pkg.
REQ-033 A sub-module bcd_digit SHALL implement one digit, with ports clk, rst_n, en, clr, max, q[3:0] and carry; carry = en & (q==max).
REQ-034 The top level SHALL chain four bcd_digit instances; each enable is the carry of the lower digit.

Verification
REQ-035 Reset, start_stop edge, then 65 ce pulses -> running=1 and disp=16'h0105.
REQ-036 Preload by counting to 59:58 with MAX_MIN_HI=5, then 2 ce pulses -> CO=1 only during the second ce; disp=16'h0000 after it.
REQ-037 RUN at 00:10, lap edge, 5 ce pulses -> disp stays 16'h0010; a second lap edge -> disp=16'h0015.
REQ-038 STOP at 00:07 with clr=1 while ce=1 in the same cycle -> disp=16'h0000 next cycle; clr pulsed in RUN -> count unchanged.
REQ-039 start_stop edge in the same cycle as ce while in RUN at 00:03 -> disp=16'h0004 and running=0; further ce pulses -> no change.
REQ-040 rst_n asserted low asynchronously mid-RUN at 12:34 -> disp=16'h0000, running=0 before the next clk edge.
